// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and parity helper
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CLEANUP
  } uart_state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  function automatic logic parity_bit(input logic [7:0] b, input int mode);
    return mode == PARITY_ODD ? ~^b : ^b;
  endfunction
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: DEPTH x 8 synchronous FIFO; a write to a full FIFO is taken when a read happens on the same edge
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_Clock,
  input  logic          i_Rst_L,
  input  logic          i_Wr,
  input  logic [7:0]    i_Wr_Data,
  input  logic          i_Rd,
  output logic [7:0]    o_Rd_Data,
  output logic          o_Full,
  output logic          o_Empty,
  output logic [CW-1:0] o_Count,
  output logic          o_Overflow
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_byte_fifo: DEPTH must be a power of two >= 2");
  end
  assign rd_ok = i_Rd & !o_Empty;
  assign wr_ok = i_Wr & (!o_Full | rd_ok);
  assign o_Full = o_Count == CW'(DEPTH);
  assign o_Empty = o_Count == '0;
  assign o_Rd_Data = mem[rd_ptr];
  // storage array, no reset needed
  always_ff @(posedge i_Clock)
    if (wr_ok) mem[wr_ptr] <= i_Wr_Data;
  // pointers wrap naturally at DEPTH; count decides full/empty
  always_ff @(posedge i_Clock)
    if (!i_Rst_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_Count <= '0;
      o_Overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_ok ? rd_ptr + AW'(1) : rd_ptr;
      o_Count <= o_Count + CW'(wr_ok) - CW'(rd_ok);
      o_Overflow <= i_Wr & !wr_ok;
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter, LSB first, optional parity, 1 or 2 stop bits
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DEPTH        = 16,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_L,
  input  logic                   i_Wr_DV,
  input  logic [7:0]             i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_Overflow,
  output logic                   o_Tx_Serial,
  output logic                   o_Tx_Active,
  output logic                   o_Tx_Done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);
  uart_state_t state, state_n;
  logic [TW-1:0] timer;
  logic [2:0] bit_idx;
  logic [7:0] shift, rd_data;
  logic empty_q, pop, t_end;
  if (CLKS_PER_BIT < 4 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_tx_buffered: illegal CLKS_PER_BIT, PARITY or STOP_BITS");
  end
  assign t_end = timer == T_MAX;
  assign pop = state == ST_IDLE && !empty_q;
  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .i_Wr      (i_Wr_DV),
    .i_Wr_Data (i_Wr_Byte),
    .i_Rd      (pop),
    .o_Rd_Data (rd_data),
    .o_Full    (o_Full),
    .o_Empty   (o_Empty),
    .o_Count   (o_Count),
    .o_Overflow(o_Overflow)
  );
  // state register; reset aborts any frame in progress
  always_ff @(posedge i_Clock)
    state <= !i_Rst_L ? ST_IDLE : state_n;
  // frame sequencing; a freshly written byte is seen one cycle late via empty_q
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    state_n = !empty_q ? ST_START : ST_IDLE;
      ST_START:   state_n = t_end ? ST_DATA : ST_START;
      ST_DATA:    state_n = t_end && bit_idx == 3'd7 ? (PARITY != PARITY_NONE ? ST_PARITY : ST_STOP) : ST_DATA;
      ST_PARITY:  state_n = t_end ? ST_STOP : ST_PARITY;
      ST_STOP:    state_n = t_end && bit_idx == 3'(STOP_BITS - 1) ? ST_CLEANUP : ST_STOP;
      ST_CLEANUP: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end
  // line, active and done decoded from state only
  always_comb begin
    o_Tx_Serial = state == ST_START ? 1'b0 : state == ST_DATA ? shift[bit_idx] : state == ST_PARITY ? parity_bit(shift, PARITY) : 1'b1;
    o_Tx_Active = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    o_Tx_Done = state == ST_CLEANUP;
  end
  // bit timer, bit/stop index, shift register and delayed empty flag
  always_ff @(posedge i_Clock)
    if (!i_Rst_L) begin
      timer <= '0;
      bit_idx <= '0;
      shift <= '0;
      empty_q <= 1'b1;
    end else begin
      timer <= (state_n != state || t_end) ? '0 : timer + TW'(1);
      bit_idx <= state == ST_IDLE ? 3'd0 : (t_end && (state == ST_DATA || state == ST_STOP)) ? bit_idx + 3'd1 : bit_idx;
      shift <= pop ? rd_data : shift;
      empty_q <= o_Empty;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized scenarios for three parity/stop configurations against a frame-level model
module tb_uart_tx_buffered;
  localparam int C = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic wr_dv[3];
  logic [7:0] wr_byte[3];
  logic full[3], empty[3], ovf[3], ser[3], act[3], done[3];
  logic [2:0] count[3];
  logic [7:0] wb[8];
  logic [7:0] q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  uart_tx_buffered #(.CLKS_PER_BIT(C), .DEPTH(D), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_dv[0]), .i_Wr_Byte(wr_byte[0]),
    .o_Full(full[0]), .o_Empty(empty[0]), .o_Count(count[0]), .o_Overflow(ovf[0]),
    .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(done[0]));
  uart_tx_buffered #(.CLKS_PER_BIT(C), .DEPTH(D), .PARITY(1), .STOP_BITS(2)) u1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_dv[1]), .i_Wr_Byte(wr_byte[1]),
    .o_Full(full[1]), .o_Empty(empty[1]), .o_Count(count[1]), .o_Overflow(ovf[1]),
    .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(done[1]));
  uart_tx_buffered #(.CLKS_PER_BIT(C), .DEPTH(D), .PARITY(2), .STOP_BITS(1)) u2 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_dv[2]), .i_Wr_Byte(wr_byte[2]),
    .o_Full(full[2]), .o_Empty(empty[2]), .o_Count(count[2]), .o_Overflow(ovf[2]),
    .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(done[2]));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int par_of(input int k);
    return k;
  endfunction
  function automatic int stop_of(input int k);
    return k == 1 ? 2 : 1;
  endfunction
  function automatic logic exp_bit(input logic [7:0] b, input int par, input int slot);
    int ones;
    ones = $countones(b);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (par != 0 && slot == 9) return par == 1 ? ones % 2 == 1 : ones % 2 == 0;
    return 1'b1;
  endfunction
  task automatic expect_frame(input int k, input logic [7:0] b, input int lead);
    int waited = 0;
    int par = par_of(k);
    int slots = 9 + (par != 0 ? 1 : 0) + stop_of(k);
    logic e;
    while (ser[k] !== 1'b0 && waited < 16) begin
      step();
      waited++;
      if (ser[k] !== 1'b0) begin
        checks++;
        if (act[k] !== 1'b0 || done[k] !== 1'b0) begin
          errors++;
          $display("FAIL idle k=%0d act=%b done=%b want 0 0", k, act[k], done[k]);
        end
      end
    end
    checks++;
    if (ser[k] !== 1'b0) begin
      errors++;
      $display("FAIL start_timeout k=%0d ser=%b want 0 within 16 cycles", k, ser[k]);
      return;
    end
    if (waited != lead) begin
      errors++;
      $display("FAIL start_lead k=%0d got %0d cycles want %0d", k, waited, lead);
    end
    for (int c = 0; c < slots * C; c++) begin
      if (c > 0) step();
      e = exp_bit(b, par, c / C);
      checks++;
      if (ser[k] !== e || act[k] !== 1'b1 || done[k] !== 1'b0) begin
        errors++;
        $display("FAIL frame k=%0d byte=%h cyc=%0d ser=%b act=%b done=%b want %b 1 0", k, b, c, ser[k], act[k], done[k], e);
      end
    end
    step();
    checks++;
    if (done[k] !== 1'b1 || act[k] !== 1'b0 || ser[k] !== 1'b1) begin
      errors++;
      $display("FAIL cleanup k=%0d done=%b act=%b ser=%b want 1 0 1", k, done[k], act[k], ser[k]);
    end
  endtask
  task automatic write_burst(input int k, input int n);
    int sz = 0;
    logic acc, pop;
    for (int i = 0; i < n; i++) begin
      pop = i == 2;
      acc = sz < D || pop;
      sz = sz - int'(pop) + int'(acc);
      if (acc) q.push_back(wb[i]);
      wr_dv[k] = 1'b1;
      wr_byte[k] = wb[i];
      step();
      wr_dv[k] = 1'b0;
      checks++;
      if (count[k] !== 3'(sz) || full[k] !== (sz == D) || empty[k] !== (sz == 0) || ovf[k] !== !acc) begin
        errors++;
        $display("FAIL fifo k=%0d wr=%0d count=%0d full=%b empty=%b ovf=%b want %0d %b %b %b",
                 k, i, count[k], full[k], empty[k], ovf[k], sz, sz == D, sz == 0, !acc);
      end
    end
    step();
    checks++;
    if (ovf[k] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pulse k=%0d ovf=%b want 0", k, ovf[k]);
    end
  endtask
  task automatic quiet(input int k, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step();
      checks++;
      if (ser[k] !== 1'b1 || act[k] !== 1'b0 || done[k] !== 1'b0 || empty[k] !== 1'b1 || count[k] !== 3'd0) begin
        errors++;
        $display("FAIL quiet k=%0d ser=%b act=%b done=%b empty=%b count=%0d want 1 0 0 1 0", k, ser[k], act[k], done[k], empty[k], count[k]);
      end
    end
  endtask
  task automatic run_scenario(input int k, input int n);
    q.delete();
    fork
      write_burst(k, n);
      expect_frame(k, wb[0], 3);
    join
    void'(q.pop_front());
    while (q.size() > 0) expect_frame(k, q.pop_front(), 2);
    quiet(k, 2 * C);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    q.delete();
  endtask
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ser[k] !== 1'b1 || act[k] !== 1'b0 || done[k] !== 1'b0 || ovf[k] !== 1'b0 ||
          empty[k] !== 1'b1 || full[k] !== 1'b0 || count[k] !== 3'd0) begin
        errors++;
        $display("FAIL reset k=%0d ser=%b act=%b done=%b ovf=%b empty=%b full=%b count=%0d want 1 0 0 0 1 0 0",
                 k, ser[k], act[k], done[k], ovf[k], empty[k], full[k], count[k]);
      end
    end
  endtask
  task automatic test_single();
    wb[0] = 8'hAB;
    run_scenario(0, 1);
  endtask
  task automatic test_back_to_back();
    wb[0] = 8'h3F;
    wb[1] = 8'h00;
    wb[2] = 8'hFF;
    run_scenario(0, 3);
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 6; i++) wb[i] = 8'($urandom);
    run_scenario(0, 6);
  endtask
  task automatic test_parity_stop();
    wb[0] = 8'h07;
    run_scenario(1, 1);
    run_scenario(2, 1);
  endtask
  task automatic test_full_pop();
    logic [7:0] x;
    for (int i = 0; i < 5; i++) wb[i] = 8'($urandom);
    x = 8'($urandom);
    q.delete();
    fork
      write_burst(0, 5);
      expect_frame(0, wb[0], 3);
    join
    void'(q.pop_front());
    step();
    checks++;
    if (full[0] !== 1'b1 || count[0] !== 3'd4) begin
      errors++;
      $display("FAIL full_before_pop full=%b count=%0d want 1 4", full[0], count[0]);
    end
    wr_dv[0] = 1'b1;
    wr_byte[0] = x;
    step();
    wr_dv[0] = 1'b0;
    checks++;
    if (ser[0] !== 1'b0 || full[0] !== 1'b1 || count[0] !== 3'd4 || ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_at_pop ser=%b full=%b count=%0d ovf=%b want 0 1 4 0", ser[0], full[0], count[0], ovf[0]);
    end
    q.push_back(x);
    expect_frame(0, q.pop_front(), 0);
    while (q.size() > 0) expect_frame(0, q.pop_front(), 2);
    quiet(0, 2 * C);
  endtask
  task automatic test_reset_mid_frame();
    int w = 0;
    wb[0] = 8'($urandom);
    wb[1] = 8'($urandom);
    q.delete();
    write_burst(0, 2);
    while (ser[0] !== 1'b0 && w < 16) begin
      step();
      w++;
    end
    checks++;
    if (ser[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_start_timeout ser=%b want 0", ser[0]);
    end
    for (int c = 0; c < 5 * C + C / 2; c++) step();
    checks++;
    if (ser[0] !== wb[0][4] || act[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit4 ser=%b act=%b want %b 1", ser[0], act[0], wb[0][4]);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (ser[0] !== 1'b1 || act[0] !== 1'b0 || count[0] !== 3'd0 || empty[0] !== 1'b1 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset ser=%b act=%b count=%0d empty=%b done=%b want 1 0 0 1 0", ser[0], act[0], count[0], empty[0], done[0]);
    end
    quiet(0, 12 * C);
  endtask
  task automatic test_random();
    int k, n;
    for (int r = 0; r < 9; r++) begin
      k = r % 3;
      n = k == 0 ? $urandom_range(1, 6) : $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wb[i] = 8'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 5)); g++) step();
      run_scenario(k, n);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_dv[k] = 1'b0;
      wr_byte[k] = 8'h00;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_parity_stop();
    test_full_pop();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
